// File: rtl/sap_pkg.sv
// sap_pkg: shared constants and dump FSM states; SEND_CK exists only with DUMP_CHECKSUM_EN.
package sap_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int FRAME_BITS = 10;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND_HI, S_SEND_LO, S_DONE, S_SEND_CK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND_HI, S_SEND_LO, S_DONE} state_t;
`endif
endpackage

// File: rtl/sap_uart_tx_byte.sv
// sap_uart_tx_byte: 8N1 byte serialiser; ready is also high in the last stop-bit cycle so frames can abut.
module sap_uart_tx_byte import sap_pkg::*; #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [8:0] sh_q, sh_d;
  logic tx_q, tx_d, act_q, act_d;
  logic step, frame_end;
  assign step = act_q && baud_q == BW'(CLKS_PER_BIT - 1);
  assign frame_end = step && bit_q == 4'(FRAME_BITS - 1);
  assign ready = !act_q || frame_end;
  assign tx = tx_q;
  // Shift register holds {stop, data}; ones shift in so the line rests high after the stop bit.
  always_comb begin
    baud_d = load || !act_q || step ? '0 : baud_q + 1'b1;
    bit_d = load ? '0 : step ? bit_q + 1'b1 : bit_q;
    sh_d = load ? {STOP_BIT, data} : step ? {STOP_BIT, sh_q[8:1]} : sh_q;
    tx_d = load ? START_BIT : step ? sh_q[0] : tx_q;
    act_d = load || (act_q && !frame_end);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
      act_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      act_q <= act_d;
    end
  end
endmodule

// File: rtl/sap_mem_dump.sv
// sap_mem_dump: reads RAM[start..end] (wrapping) and sends each word as two UART bytes, high first.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module sap_mem_dump #(
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  import sap_pkg::*;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, last_q, last_d;
  logic [7:0] lo_q, lo_d, ld_data;
  logic load, ready;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0] ck_q, ck_d;
`endif
  assign mem_rd_en = state_q == S_READ;
  assign mem_addr = cur_q;
  assign busy = state_q != S_IDLE && state_q != S_DONE;
  assign done = state_q == S_DONE;
  // The high byte is loaded straight from mem_rdata so its start bit leaves on the cycle after WAIT.
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    last_d = last_q;
    lo_d = lo_q;
    load = 1'b0;
    ld_data = lo_q;
`ifdef DUMP_CHECKSUM_EN
    ck_d = ck_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_READ;
        cur_d = start_addr;
        last_d = end_addr;
`ifdef DUMP_CHECKSUM_EN
        ck_d = '0;
`endif
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        lo_d = mem_rdata[7:0];
        load = 1'b1;
        ld_data = mem_rdata[15:8];
        state_d = S_SEND_HI;
      end
      S_SEND_HI: if (ready) begin
        load = 1'b1;
        state_d = S_SEND_LO;
      end
      S_SEND_LO: if (ready) begin
        if (cur_q != last_q) begin
          cur_d = cur_q + 1'b1;
          state_d = S_READ;
        end else begin
`ifdef DUMP_CHECKSUM_EN
          load = 1'b1;
          ld_data = ck_q;
          state_d = S_SEND_CK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_SEND_CK: if (ready) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef DUMP_CHECKSUM_EN
    if (load && state_q != S_SEND_LO) ck_d = ck_q ^ ld_data;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q <= '0;
      last_q <= '0;
      lo_q <= '0;
`ifdef DUMP_CHECKSUM_EN
      ck_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      last_q <= last_d;
      lo_q <= lo_d;
`ifdef DUMP_CHECKSUM_EN
      ck_q <= ck_d;
`endif
    end
  end
  sap_uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst(rst),
    .load(load),
    .data(ld_data),
    .tx(tx),
    .ready(ready)
  );
endmodule

// File: doc/sap_mem_dump.md
Name: sap_mem_dump

Overview:
Readback engine for the SAP RAM (256 x 16). On a start request it reads a contiguous address range from RAM and serialises each word as two 8N1 UART bytes on a single TX line, high byte first. It lets bench and silicon check RAM contents, including results written by the program, from the pins.

Parameters:
DATA_W, 16, RAM word width; must be 16 (two bytes per word).
ADDR_W, 8, RAM address width.
CLKS_PER_BIT, 4, clk cycles per UART bit; must be at least 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request; sampled only in IDLE.
start_addr  input  ADDR_W  first address to dump; latched on accepted start.
end_addr  input  ADDR_W  last address to dump, inclusive; latched on accepted start.
mem_rd_en  output  1  RAM read strobe.
mem_addr  output  ADDR_W  RAM read address.
mem_rdata  input  DATA_W  RAM read data; valid the cycle after mem_rd_en.
tx  output  1  UART serial out; idles high.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset values: tx=1, busy=0, done=0, mem_rd_en=0, mem_addr=0. All FSM state, counters and shift registers are cleared. Reset mid-dump aborts immediately: tx returns high on the next edge and no done pulse is produced.
- FSM states are IDLE, READ, WAIT, SEND_HI, SEND_LO, DONE (plus SEND_CK when the optional feature is compiled in).
- IDLE: start=1 latches start_addr and end_addr into cur_addr and last_addr, then goes to READ. start is ignored in every other state.
- READ, 1 cycle: mem_rd_en=1 and mem_addr=cur_addr. Next state is WAIT.
- WAIT, 1 cycle: capture mem_rdata into word_reg. Next state is SEND_HI.
- SEND_HI and SEND_LO each send one frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- SEND_HI sends word_reg[15:8]. SEND_LO sends word_reg[7:0] and starts on the cycle immediately after the SEND_HI stop bit, with no gap.
- After the SEND_LO stop bit:
  - if cur_addr==last_addr, go to DONE;
  - otherwise cur_addr increments modulo 256 and the FSM goes to READ.
- Wrap-around: if end_addr < start_addr, addresses run start..255, 0..end. Word count = ((end-start) mod 256) + 1. start_addr==end_addr dumps exactly 1 word.
- DONE, 1 cycle: done=1, then go to IDLE. busy falls in the same cycle done rises.
- tx is 1 in IDLE, READ, WAIT and DONE. The line therefore sees 2 idle-high cycles between consecutive words.
- Timing: accepted start at edge E. READ occupies cycle E+1 and WAIT cycle E+2. The first start bit drives tx from cycle E+3.
- Total cycles from start to done = N*(2 + 20*CLKS_PER_BIT) + 1 for N words.
- tx is driven from a flop, never combinationally.

Optional Feature:
Macro DUMP_CHECKSUM_EN.
- Defined: after the last word's SEND_LO, the FSM enters SEND_CK. It sends one extra frame carrying the 8-bit XOR of every data byte sent in this dump, then goes to DONE. The checksum register clears on accepted start. Total cycles increase by 10*CLKS_PER_BIT.
- Undefined: SEND_CK and the checksum register do not exist, and the FSM goes SEND_LO to DONE.

Decomposition:
- sap_pkg holds the state enum for this FSM, DATA_W/ADDR_W constants, and the UART framing constants (FRAME_BITS=10, START_BIT=0, STOP_BIT=1).
- One sub-module, sap_uart_tx_byte. Interface: load pulse and 8-bit data in; tx and ready out. It owns the baud counter, bit counter and shift register.
- The top FSM sequences the RAM reads and the byte loads.

Test Plan:
1. RAM mem[10]=0x0000, mem[11]=0x0B00, mem[12]=0x0201; start_addr=10, end_addr=12, CLKS_PER_BIT=4. Decoded byte stream must be 00 00 0B 00 02 01. done must pulse exactly 3*(2+80)+1 = 247 cycles after start.
2. start_addr=end_addr=1 with mem[1]=0x0001 -> bytes 00 01. busy is high for 82 cycles, then done pulses.
3. Wrap case: start_addr=254, end_addr=1 with mem[254]=0xAAAA, mem[255]=0x5555, mem[0]=0x0000, mem[1]=0x0001. mem_addr sequence must be 254,255,0,1 and bytes must be AA AA 55 55 00 00 00 01.
4. Assert start again and change start_addr mid-dump -> no effect on the address sequence or byte stream, and exactly one done pulse.
5. Assert rst for 1 cycle during the SEND_HI data bits -> next edge tx=1, busy=0, no done. A fresh start afterwards dumps correctly.
6. With DUMP_CHECKSUM_EN defined, repeat scenario 1 -> 7th byte is 0x08 (00^00^0B^00^02^01), and done pulses 40 cycles later than in scenario 1.
